// File: rtl/text_pkg.sv
// Shared constants, opcodes and FSM state for the text-mode display path.
// Imported by the command engine, the display block and the CPU register file.
package text_pkg;

    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int BUF_SIZE = COLS * ROWS;

    localparam logic [7:0] CMD_SET_CHAR    = 8'd0;
    localparam logic [7:0] CMD_APPEND_CHAR = 8'd1;
    localparam logic [7:0] CMD_SET_CURSOR  = 8'd2;
    localparam logic [7:0] CMD_CLEAR       = 8'd3;
    localparam logic [7:0] CMD_NEWLINE     = 8'd4;
    localparam logic [7:0] CMD_CLR_ERR     = 8'd5;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // row*cols+col as a sum of shifted rows; cols is a constant at every call
    function automatic logic [15:0] lin_index(
        input int         cols,
        input logic [7:0] row,
        input logic [7:0] col
    );
        logic [15:0] acc;
        acc = {8'd0, col};
        for (int i = 0; i < 16; i++) begin
            if (cols[i]) acc = acc + ({8'd0, row} << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor: column/row registers with wrap and a registered linear index.
// All update requests arrive from a single accepted command, so they never overlap.
module text_cursor
    import text_pkg::*;
#(
    parameter int COLS   = text_pkg::COLS,
    parameter int ROWS   = text_pkg::ROWS,
    parameter int ADDR_W = 12
) (
    input  logic              cpu_clock,
    input  logic              reset,
    input  logic              home,
    input  logic              set_en,
    input  logic [7:0]        set_col,
    input  logic [7:0]        set_row,
    input  logic              advance,
    input  logic              newline,
    output logic [ADDR_W-1:0] cursor_pos
);

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    logic [7:0] col;
    logic [7:0] row;
    logic [7:0] col_nx;
    logic [7:0] row_nx;
    logic [7:0] row_inc;

    assign row_inc = (row == LAST_ROW) ? 8'd0 : row + 8'd1;

    always_comb begin
        col_nx = col;
        row_nx = row;
        if (home) begin
            col_nx = 8'd0;
            row_nx = 8'd0;
        end else if (set_en) begin
            col_nx = set_col;
            row_nx = set_row;
        end else if (advance) begin
            if (col == LAST_COL) begin
                col_nx = 8'd0;
                row_nx = row_inc;
            end else begin
                col_nx = col + 8'd1;
            end
        end else if (newline) begin
            col_nx = 8'd0;
            row_nx = row_inc;
        end
    end

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            col        <= 8'd0;
            row        <= 8'd0;
            cursor_pos <= '0;
        end else begin
            col        <= col_nx;
            row        <= row_nx;
            cursor_pos <= ADDR_W'(lin_index(COLS, row_nx, col_nx));
        end
    end

endmodule

// File: rtl/text_cmd_engine.sv
// Executes latched text commands as write sequences into text buffer port A.
// Single-write commands complete in IDLE; only CLEAR occupies the FSM.
module text_cmd_engine
    import text_pkg::*;
#(
    parameter int COLS   = text_pkg::COLS,
    parameter int ROWS   = text_pkg::ROWS,
    parameter int ADDR_W = 12
) (
    input  logic              cpu_clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_code,
    input  logic [7:0]        arg1,
    input  logic [7:0]        arg2,
    input  logic [7:0]        arg3,
    output logic              busy,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic [ADDR_W-1:0] cursor_pos,
    output logic              err
);

    localparam logic [7:0]        COLS8     = 8'(COLS);
    localparam logic [7:0]        ROWS8     = 8'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    state_t            state;
    logic              accept;
    logic              in_range;
    logic [ADDR_W-1:0] char_addr;

    assign accept    = cmd_valid && (state == ST_IDLE);
    assign in_range  = (arg2 < COLS8) && (arg3 < ROWS8);
    assign char_addr = ADDR_W'(lin_index(COLS, arg3, arg2));

    text_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .cpu_clock  (cpu_clock),
        .reset      (reset),
        .home       (accept && cmd_code == CMD_CLEAR),
        .set_en     (accept && cmd_code == CMD_SET_CURSOR && in_range),
        .set_col    (arg2),
        .set_row    (arg3),
        .advance    (accept && cmd_code == CMD_APPEND_CHAR),
        .newline    (accept && cmd_code == CMD_NEWLINE),
        .cursor_pos (cursor_pos)
    );

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_data <= 8'd0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    buf_we <= 1'b0;
                    if (cmd_valid) begin
                        case (cmd_code)
                            CMD_SET_CHAR: begin
                                if (in_range) begin
                                    buf_we   <= 1'b1;
                                    buf_addr <= char_addr;
                                    buf_data <= arg1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            CMD_APPEND_CHAR: begin
                                buf_we   <= 1'b1;
                                buf_addr <= cursor_pos;
                                buf_data <= arg1;
                            end
                            CMD_SET_CURSOR: begin
                                if (!in_range) err <= 1'b1;
                            end
                            CMD_CLEAR: begin
                                state    <= ST_CLEAR;
                                busy     <= 1'b1;
                                buf_we   <= 1'b1;
                                buf_addr <= '0;
                                buf_data <= arg1;
                            end
                            CMD_NEWLINE: begin
                            end
                            CMD_CLR_ERR: err <= 1'b0;
                            default:     err <= 1'b1;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    // any command arriving mid-clear is dropped
                    if (cmd_valid) err <= 1'b1;
                    if (buf_addr == LAST_ADDR) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        buf_we <= 1'b0;
                    end else begin
                        buf_addr <= buf_addr + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_cmd_engine.sv
// Directed bench for text_cmd_engine with immediate-assertion checks.
module tb_text_cmd_engine;

    logic        cpu_clock;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [7:0]  arg1;
    logic [7:0]  arg2;
    logic [7:0]  arg3;
    logic        busy;
    logic        buf_we;
    logic [11:0] buf_addr;
    logic [7:0]  buf_data;
    logic [11:0] cursor_pos;
    logic        err;

    int errors = 0;
    int checks = 0;
    int bad;

    text_cmd_engine dut (
        .cpu_clock  (cpu_clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .arg1       (arg1),
        .arg2       (arg2),
        .arg3       (arg3),
        .busy       (busy),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .cursor_pos (cursor_pos),
        .err        (err)
    );

    initial cpu_clock = 1'b0;
    always #5 cpu_clock = ~cpu_clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // present a command for one edge; returns #1 after that edge
    task automatic issue(input logic [7:0] c, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
        @(negedge cpu_clock);
        cmd_valid = 1'b1;
        cmd_code  = c;
        arg1      = a1;
        arg2      = a2;
        arg3      = a3;
        @(posedge cpu_clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge cpu_clock);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = 8'd0;
        arg1      = 8'd0;
        arg2      = 8'd0;
        arg3      = 8'd0;
        repeat (3) @(posedge cpu_clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_we", buf_we, 0);
        check("rst_addr", buf_addr, 0);
        check("rst_data", buf_data, 0);
        check("rst_pos", cursor_pos, 0);
        check("rst_err", err, 0);
        @(negedge cpu_clock);
        reset = 1'b1;

        issue(8'd0, 8'h41, 8'd5, 8'd2);
        check("set_char_we", buf_we, 1);
        check("set_char_addr", buf_addr, 165);
        check("set_char_data", buf_data, 8'h41);
        check("set_char_pos", cursor_pos, 0);
        check("set_char_err", err, 0);
        step();
        check("set_char_we_drop", buf_we, 0);

        issue(8'd2, 8'd0, 8'd79, 8'd29);
        check("setcur_pos", cursor_pos, 2399);
        check("setcur_no_we", buf_we, 0);
        issue(8'd1, 8'h42, 8'd0, 8'd0);
        check("app1_we", buf_we, 1);
        check("app1_addr", buf_addr, 2399);
        check("app1_data", buf_data, 8'h42);
        check("app1_pos", cursor_pos, 0);
        issue(8'd1, 8'h42, 8'd0, 8'd0);
        check("app2_we", buf_we, 1);
        check("app2_addr", buf_addr, 0);
        check("app2_pos", cursor_pos, 1);

        issue(8'd3, 8'h20, 8'd0, 8'd0);
        check("clr_pos", cursor_pos, 0);
        bad = 0;
        for (int i = 0; i < 2400; i++) begin
            if (!(busy === 1'b1 && buf_we === 1'b1 &&
                  buf_addr === 12'(i) && buf_data === 8'h20))
                bad++;
            @(negedge cpu_clock);
            if (i == 500) begin
                cmd_valid = 1'b1;
                cmd_code  = 8'd1;
                arg1      = 8'h58;
            end
            @(posedge cpu_clock);
            #1;
            cmd_valid = 1'b0;
        end
        check("clr_sequence_bad_cycles", bad, 0);
        check("clr_busy_end", busy, 0);
        check("clr_we_end", buf_we, 0);
        check("clr_collision_err", err, 1);
        check("clr_drop_pos", cursor_pos, 0);
        issue(8'd5, 8'd0, 8'd0, 8'd0);
        check("clr_err_cleared", err, 0);

        issue(8'd0, 8'h33, 8'd80, 8'd0);
        check("oob_col_we", buf_we, 0);
        check("oob_col_err", err, 1);
        issue(8'd5, 8'd0, 8'd0, 8'd0);
        issue(8'd9, 8'h33, 8'd1, 8'd1);
        check("bad_op_we", buf_we, 0);
        check("bad_op_err", err, 1);
        issue(8'd5, 8'd0, 8'd0, 8'd0);
        check("clr_err", err, 0);
        issue(8'd2, 8'd0, 8'd4, 8'd30);
        check("oob_row_pos", cursor_pos, 0);
        check("oob_row_err", err, 1);
        issue(8'd5, 8'd0, 8'd0, 8'd0);

        issue(8'd2, 8'd0, 8'd10, 8'd29);
        check("cur_29_10", cursor_pos, 2330);
        issue(8'd4, 8'd0, 8'd0, 8'd0);
        check("nl_wrap", cursor_pos, 0);
        issue(8'd2, 8'd0, 8'd7, 8'd3);
        check("cur_3_7", cursor_pos, 247);
        issue(8'd4, 8'd0, 8'd0, 8'd0);
        check("nl_row4", cursor_pos, 320);
        check("nl_no_we", buf_we, 0);

        issue(8'd3, 8'h2e, 8'd0, 8'd0);
        repeat (1000) step();
        check("abort_addr", buf_addr, 1000);
        check("abort_busy_pre", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_we", buf_we, 0);
        check("abort_pos", cursor_pos, 0);
        @(negedge cpu_clock);
        reset = 1'b1;
        issue(8'd0, 8'h55, 8'd0, 8'd0);
        check("post_we", buf_we, 1);
        check("post_addr", buf_addr, 0);
        check("post_data", buf_data, 8'h55);
        check("post_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_cmd_engine.md
Name: text_cmd_engine

Overview:
- Command executor directly upstream of the text-mode display block.
- Accepts one latched command (code plus three argument bytes) from the CPU register file and performs the matching write sequence into port A of the 80x30 text buffer.
- Owns the text cursor.
- Provides busy, error and cursor status so the CPU-side register file can gate and report commands.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 30, text rows per screen.
- ADDR_W, 12, text buffer address width; must satisfy COLS*ROWS <= 2^ADDR_W.

Ports:
- cpu_clock  in  1  sole clock; also clocks buffer port A.
- reset  in  1  asynchronous, active-low.
- cmd_valid  in  1  single-cycle strobe: command fields are valid.
- cmd_code  in  8  command opcode.
- arg1  in  8  character code or fill value.
- arg2  in  8  column.
- arg3  in  8  row.
- busy  out  1  high while a multi-cycle command runs.
- buf_we  out  1  text buffer write enable.
- buf_addr  out  ADDR_W  text buffer write address.
- buf_data  out  8  text buffer write data.
- cursor_pos  out  ADDR_W  linear cursor index, row*COLS+col.
- err  out  1  sticky error flag.

Behaviour:
- One clock, cpu_clock. Reset is asynchronous and active-low.
- Reset values: busy=0, buf_we=0, buf_addr=0, buf_data=0, cursor_pos=0, err=0. FSM returns to IDLE.
- Acceptance: a command is accepted on a cpu_clock edge where cmd_valid=1 and the FSM is in IDLE.
- Busy collision: cmd_valid=1 in any other state is dropped, sets err, and has no other effect.
- FSM states:
  - IDLE: accepts commands.
  - CLEAR: busy=1, one buffer write per cycle.
  - Single-write commands never leave IDLE. This allows back-to-back single-write commands every cycle.
- Opcodes:
  - 0 SET_CHAR: if arg2<COLS and arg3<ROWS, write arg1 at arg3*COLS+arg2. Otherwise no write and err=1. Cursor is unchanged.
  - 1 APPEND_CHAR: write arg1 at cursor_pos, then advance the cursor. The column wraps to 0 with row+1. Row ROWS-1 wraps to row 0 (no scrolling).
  - 2 SET_CURSOR: set the cursor to (arg3, arg2) if in range; else err=1 and the cursor is unchanged. No write.
  - 3 CLEAR: write arg1 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle. Cursor is set to 0 at acceptance.
  - 4 NEWLINE: col=0, row+1, wrapping to row 0 after ROWS-1. No write.
  - 5 CLR_ERR: err=0. If the same edge also raises an error, set wins (not reachable in IDLE).
  - Other codes: err=1, no action.
- Latency, single-write commands: accepted at edge N; buf_we=1 with buf_addr/buf_data valid for exactly the cycle after edge N. Cursor and cursor_pos update at edge N.
- Latency, CLEAR: accepted at edge N.
  - busy=1 and buf_we=1 from the cycle after N through the cycle carrying address COLS*ROWS-1 (2400 write cycles at the defaults).
  - busy and buf_we drop at the following edge, after which the next command is accepted.
  - No idle gap between consecutive CLEAR writes.
- All outputs are registered; buf_we is low whenever no write is issued.
- Cursor is held internally as separate col/row registers.
- cursor_pos and write addresses use shift-add row*COLS (80=64+16 at the default) computed in ADDR_W bits. No divider.
- Range checks compare the full 8-bit args; arg values 80..255 or 30..255 are errors at the defaults.
- Reset mid-CLEAR aborts immediately: buf_we=0, busy=0, cursor=0. The buffer is left partially filled and there is no resume.

Decomposition:
- Shared package text_pkg holds:
  - opcode constants CMD_SET_CHAR=0, CMD_APPEND_CHAR=1, CMD_SET_CURSOR=2, CMD_CLEAR=3, CMD_NEWLINE=4, CMD_CLR_ERR=5;
  - COLS, ROWS and the buffer size constant;
  - the FSM state typedef.
- The display block and the CPU register file import the same package.
- One natural sub-module: text_cursor, holding the col/row registers, the advance/newline/set logic with wrap, and the linear index output.

Test Plan:
- Reset, then SET_CHAR arg1=0x41, arg2=5, arg3=2 -> one cycle later buf_we=1, buf_addr=165, buf_data=0x41; cursor_pos stays 0; err=0.
- SET_CURSOR (29,79), then APPEND_CHAR 0x42 on two consecutive cycles -> writes at 2399 then 0 on consecutive cycles; final cursor_pos=1.
- CLEAR arg1=0x20 -> busy high for exactly 2400 cycles; addresses 0..2399 each written once with 0x20, ascending; cursor_pos=0; an APPEND_CHAR issued mid-clear is dropped and sets err.
- SET_CHAR with arg2=80, then opcode 9 -> no buf_we in either case; err=1; CLR_ERR -> err=0.
- SET_CURSOR (29,10), NEWLINE -> cursor_pos=0; SET_CURSOR (3,7), NEWLINE -> cursor_pos=320.
- Assert reset at clear write 1000 -> busy and buf_we drop asynchronously, cursor_pos=0; after release, SET_CHAR is accepted normally.
